// File: rtl/button_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// button_conditioner_pkg
// Shared constants and types for the push-button conditioning block:
//   - button bit positions within the 4-bit button vectors
//   - per-button debounce FSM state encoding
//   - default debounce length derived from the 40 MHz system clock
// ---------------------------------------------------------------------------
package button_conditioner_pkg;

  localparam int CLK_FREQ_HZ      = 40_000_000;
  localparam int DEBOUNCE_TIME_US = 5_000;
  localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_FREQ_HZ / 1_000_000) * DEBOUNCE_TIME_US;
  localparam int CNT_WIDTH_DEFAULT       = 20;

  localparam int NUM_BTN       = 4;
  localparam int BTN_IDX_LEFT  = 0;
  localparam int BTN_IDX_RIGHT = 1;
  localparam int BTN_IDX_A     = 2;
  localparam int BTN_IDX_B     = 3;

  // Buttons whose accepted press fires LAUNCH.
  localparam logic [NUM_BTN-1:0] LAUNCH_MASK = (NUM_BTN'(1) << BTN_IDX_A) | (NUM_BTN'(1) << BTN_IDX_B);

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'b00,
    ST_PRESS_PEND   = 2'b01,
    ST_HELD         = 2'b10,
    ST_RELEASE_PEND = 2'b11
  } btn_state_e;

endpackage

// File: rtl/button_conditioner_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
// One button bit: two-flop synchroniser, hold-time counter, debounce FSM and
// registered level / press / release outputs.
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_raw          raw asynchronous button input (active-high)
//   o_level        debounced level (1 in HELD and RELEASE_PEND)
//   o_press        one-cycle pulse on an accepted 0->1 transition
//   o_release_ev   one-cycle pulse on an accepted 1->0 transition
//   o_press_fire   combinational "press accepted at the next edge"; lets the
//                  parent register a derived pulse in the same cycle as o_press
// ---------------------------------------------------------------------------
module button_debounce
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release_ev,
  output logic o_press_fire
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [1:0]           r_sync;
  btn_state_e           r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_level;
  logic                 r_press;
  logic                 r_release;

  logic                 w_sync;
  logic                 w_cnt_done;
  logic                 w_press_fire;
  logic                 w_release_fire;
  logic [CNT_WIDTH-1:0] w_cnt_inc;

  assign w_sync         = r_sync[1];
  assign w_cnt_done     = (r_cnt == CNT_LAST);
  assign w_press_fire   = (r_state == ST_PRESS_PEND) && w_sync && w_cnt_done;
  assign w_release_fire = (r_state == ST_RELEASE_PEND) && !w_sync && w_cnt_done;
  // Saturating increment: the counter must never wrap back into range.
  assign w_cnt_inc      = (r_cnt == {CNT_WIDTH{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync    <= 2'b00;
      r_state   <= ST_RELEASED;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_raw};
      r_press   <= w_press_fire;
      r_release <= w_release_fire;
      case (r_state)
        ST_RELEASED: begin
          if (w_sync) begin
            r_state <= ST_PRESS_PEND;
            r_cnt   <= '0;
          end
        end
        ST_PRESS_PEND: begin
          if (!w_sync) begin
            r_state <= ST_RELEASED;      // bounce rejected
          end else if (w_cnt_done) begin
            r_state <= ST_HELD;
            r_level <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_HELD: begin
          if (!w_sync) begin
            r_state <= ST_RELEASE_PEND;
            r_cnt   <= '0;
          end
        end
        ST_RELEASE_PEND: begin
          if (w_sync) begin
            r_state <= ST_HELD;          // bounce rejected, level stays 1
          end else if (w_cnt_done) begin
            r_state <= ST_RELEASED;
            r_level <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= ST_RELEASED;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign o_level      = r_level;
  assign o_press      = r_press;
  assign o_release_ev = r_release;
  assign o_press_fire = w_press_fire;

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Conditions the four raw push buttons (LEFT, RIGHT, A, B) for the game
// controller: per-button synchronise + debounce, plus a merged A|B launch pulse.
// Ports:
//   i_clk              system clock (40 MHz)
//   i_rst_n            asynchronous active-low reset
//   i_btn_raw[3:0]     raw buttons, active-high; bit0 LEFT, 1 RIGHT, 2 A, 3 B
//   o_btn_level[3:0]   debounced levels
//   o_btn_press[3:0]   one-cycle accepted-press pulses
//   o_btn_release_ev[3:0] one-cycle accepted-release pulses
//   o_launch           one-cycle pulse, press of A or B (single pulse if both)
// ---------------------------------------------------------------------------
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_BTN-1:0] i_btn_raw,
  output logic [NUM_BTN-1:0] o_btn_level,
  output logic [NUM_BTN-1:0] o_btn_press,
  output logic [NUM_BTN-1:0] o_btn_release_ev,
  output logic               o_launch
);

  logic [NUM_BTN-1:0] w_press_fire;
  logic               r_launch;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_WIDTH       (CNT_WIDTH)
      ) u_debounce (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_raw        (i_btn_raw[gi]),
        .o_level      (o_btn_level[gi]),
        .o_press      (o_btn_press[gi]),
        .o_release_ev (o_btn_release_ev[gi]),
        .o_press_fire (w_press_fire[gi])
      );
    end
  endgenerate

  // Registered from the same "about to accept" term that sets BTN_PRESS, so
  // LAUNCH lines up with the press pulse and A+B together yields one pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_launch <= 1'b0;
    end else begin
      r_launch <= |(w_press_fire & LAUNCH_MASK);
    end
  end

  assign o_launch = r_launch;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic [3:0] lvl8, pr8, rl8, lvl2, pr2, rl2;
  logic       ln8, ln2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  button_conditioner #(.DEBOUNCE_CYCLES(8), .CNT_WIDTH(4)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn_raw(btn),
    .o_btn_level(lvl8), .o_btn_press(pr8), .o_btn_release_ev(rl8), .o_launch(ln8)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(2), .CNT_WIDTH(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn_raw(btn),
    .o_btn_level(lvl2), .o_btn_press(pr2), .o_btn_release_ev(rl2), .o_launch(ln2)
  );

  // Reference model. A button's accepted level flips once the input, as seen
  // two edges late, has disagreed with the accepted level for D+1 consecutive
  // edges; the flip and its pulse are visible right after that edge.
  // Index 0 models DEBOUNCE_CYCLES=8, index 1 models DEBOUNCE_CYCLES=2.
  int         dval[2] = '{8, 2};
  int         run[2][4];
  logic [3:0] ml[2], mp[2], mr[2];
  logic       mlaunch[2];
  logic [3:0] m_d1, m_d2;

  task automatic model_reset();
    m_d1 = 4'b0000;
    m_d2 = 4'b0000;
    for (int m = 0; m < 2; m++) begin
      ml[m] = 4'b0000; mp[m] = 4'b0000; mr[m] = 4'b0000; mlaunch[m] = 1'b0;
      for (int i = 0; i < 4; i++) run[m][i] = 0;
    end
  endtask

  task automatic model_edge(input logic [3:0] raw);
    logic [3:0] s;
    s = m_d2;
    for (int m = 0; m < 2; m++) begin
      mp[m] = 4'b0000;
      mr[m] = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (s[i] != ml[m][i]) begin
          run[m][i] = run[m][i] + 1;
          if (run[m][i] == dval[m] + 1) begin
            ml[m][i] = s[i];
            if (s[i]) mp[m][i] = 1'b1;
            else      mr[m][i] = 1'b1;
            run[m][i] = 0;
          end
        end else begin
          run[m][i] = 0;
        end
      end
      mlaunch[m] = mp[m][2] | mp[m][3];
    end
    m_d2 = m_d1;
    m_d1 = raw;
  endtask

  // Drive raw inputs, advance one clock, update the model, sample at edge+1.
  task automatic tick(input logic [3:0] raw);
    btn = raw;
    @(posedge clk);
    if (rst_n) model_edge(raw);
    else       model_reset();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) tick(4'b1111);
    checks++;
    if ({lvl8, pr8, rl8, ln8, lvl2, pr2, rl2, ln2} !== 26'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=0", {lvl8, pr8, rl8, ln8, lvl2, pr2, rl2, ln2});
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick(4'b1111);
      checks++;
      if ({pr8, ln8} !== ((k == 11) ? 5'b11111 : 5'b00000)) begin
        failures++;
        $display("FAIL reset_press_d8 k=%0d got press=%b launch=%b required=%b", k, pr8, ln8, (k == 11) ? 5'b11111 : 5'b00000);
      end
      checks++;
      if ({lvl8, pr8, rl8, ln8, lvl2, pr2, rl2, ln2} !== {ml[0], mp[0], mr[0], mlaunch[0], ml[1], mp[1], mr[1], mlaunch[1]}) begin
        failures++;
        $display("FAIL reset_model k=%0d got=%b required=%b", k, {lvl8, pr8, rl8, ln8, lvl2, pr2, rl2, ln2}, {ml[0], mp[0], mr[0], mlaunch[0], ml[1], mp[1], mr[1], mlaunch[1]});
      end
    end
    checks++;
    if (lvl8 !== 4'b1111) begin
      failures++;
      $display("FAIL reset_level_held got=%b required=1111", lvl8);
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  // Runs a fixed raw pattern and compares both DUTs with the model each cycle.
  task automatic test_clean_press();
    for (int k = 1; k <= 14; k++) tick(4'b0000);
    for (int k = 1; k <= 34; k++) begin
      tick((k <= 20) ? 4'b0001 : 4'b0000);
      checks++;
      if ({pr8, rl8} !== {((k == 11) ? 4'b0001 : 4'b0000), ((k == 31) ? 4'b0001 : 4'b0000)}) begin
        failures++;
        $display("FAIL clean_pulses_d8 k=%0d got press=%b release=%b", k, pr8, rl8);
      end
      checks++;
      if ({lvl8, pr8, rl8, ln8, lvl2, pr2, rl2, ln2} !== {ml[0], mp[0], mr[0], mlaunch[0], ml[1], mp[1], mr[1], mlaunch[1]}) begin
        failures++;
        $display("FAIL clean_model k=%0d got=%b required=%b", k, {lvl8, pr8, rl8, ln8, lvl2, pr2, rl2, ln2}, {ml[0], mp[0], mr[0], mlaunch[0], ml[1], mp[1], mr[1], mlaunch[1]});
      end
    end
    $display("test_clean_press done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_bounce();
    int presses = 0;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) begin
        tick((k < 5) ? 4'b0010 : 4'b0000);
        if (pr8 != 4'b0000) presses++;
        checks++;
        if ({lvl8, pr8, rl8, ln8, lvl2, pr2, rl2, ln2} !== {ml[0], mp[0], mr[0], mlaunch[0], ml[1], mp[1], mr[1], mlaunch[1]}) begin
          failures++;
          $display("FAIL bounce_model b=%0d k=%0d got=%b required=%b", b, k, {lvl8, pr8, rl8, ln8, lvl2, pr2, rl2, ln2}, {ml[0], mp[0], mr[0], mlaunch[0], ml[1], mp[1], mr[1], mlaunch[1]});
        end
      end
    end
    checks++;
    if (presses != 0) begin
      failures++;
      $display("FAIL bounce_no_pulse got=%0d presses required=0", presses);
    end
    for (int k = 1; k <= 14; k++) begin
      tick(4'b0010);
      checks++;
      if (pr8 !== ((k == 11) ? 4'b0010 : 4'b0000)) begin
        failures++;
        $display("FAIL bounce_final_press k=%0d got=%b required=%b", k, pr8, (k == 11) ? 4'b0010 : 4'b0000);
      end
    end
    for (int k = 1; k <= 14; k++) tick(4'b0000);
    $display("test_bounce done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_launch();
    int n = 0;
    int first = -1;
    int second = -1;
    for (int k = 1; k <= 14; k++) begin
      tick(4'b1100);
      if (ln8) n++;
    end
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL launch_merge got=%0d pulses required=1", n);
    end
    for (int k = 1; k <= 14; k++) tick(4'b0000);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick((k <= 3) ? 4'b0100 : 4'b1100);
      if (ln8) begin
        n++;
        if (first < 0) first = k; else second = k;
      end
      checks++;
      if ({lvl8, pr8, rl8, ln8, lvl2, pr2, rl2, ln2} !== {ml[0], mp[0], mr[0], mlaunch[0], ml[1], mp[1], mr[1], mlaunch[1]}) begin
        failures++;
        $display("FAIL launch_model k=%0d got=%b required=%b", k, {lvl8, pr8, rl8, ln8, lvl2, pr2, rl2, ln2}, {ml[0], mp[0], mr[0], mlaunch[0], ml[1], mp[1], mr[1], mlaunch[1]});
      end
    end
    checks++;
    if (n != 2 || first != 11 || second != 14) begin
      failures++;
      $display("FAIL launch_split got count=%0d at %0d,%0d required 2 at 11,14", n, first, second);
    end
    for (int k = 1; k <= 14; k++) tick(4'b0000);
    $display("test_launch done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid();
    int presses = 0;
    for (int k = 1; k <= 8; k++) begin
      tick(4'b0001);
      if (pr8 != 4'b0000) presses++;
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({lvl8, pr8, rl8, ln8, lvl2, pr2, rl2, ln2} !== 26'd0) begin
      failures++;
      $display("FAIL midreset_async got=%b required=0", {lvl8, pr8, rl8, ln8, lvl2, pr2, rl2, ln2});
    end
    for (int k = 0; k < 2; k++) begin
      tick(4'b0001);
      if (pr8 != 4'b0000) presses++;
    end
    rst_n = 1'b1;
    checks++;
    if (presses != 0) begin
      failures++;
      $display("FAIL midreset_aborted got=%0d presses required=0", presses);
    end
    for (int k = 1; k <= 14; k++) begin
      tick(4'b0001);
      checks++;
      if (pr8 !== ((k == 11) ? 4'b0001 : 4'b0000)) begin
        failures++;
        $display("FAIL midreset_press k=%0d got=%b required=%b", k, pr8, (k == 11) ? 4'b0001 : 4'b0000);
      end
      checks++;
      if ({lvl8, pr8, rl8, ln8, lvl2, pr2, rl2, ln2} !== {ml[0], mp[0], mr[0], mlaunch[0], ml[1], mp[1], mr[1], mlaunch[1]}) begin
        failures++;
        $display("FAIL midreset_model k=%0d got=%b required=%b", k, {lvl8, pr8, rl8, ln8, lvl2, pr2, rl2, ln2}, {ml[0], mp[0], mr[0], mlaunch[0], ml[1], mp[1], mr[1], mlaunch[1]});
      end
    end
    for (int k = 1; k <= 14; k++) tick(4'b0000);
    $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_counter_limit();
    int presses2 = 0;
    int presses8 = 0;
    int drops = 0;
    for (int k = 1; k <= 1000; k++) begin
      tick(4'b0001);
      if (pr2[0]) presses2++;
      if (pr8[0]) presses8++;
      if (k > 5 && lvl2[0] !== 1'b1) drops++;
      if (rl2 != 4'b0000) drops++;
    end
    checks++;
    if (presses2 != 1 || presses8 != 1 || drops != 0) begin
      failures++;
      $display("FAIL counter_limit got presses d2=%0d d8=%0d level_drops=%0d required 1 1 0", presses2, presses8, drops);
    end
    checks++;
    if ({lvl8, lvl2} !== {ml[0], ml[1]}) begin
      failures++;
      $display("FAIL counter_limit_level got=%b required=%b", {lvl8, lvl2}, {ml[0], ml[1]});
    end
    for (int k = 1; k <= 14; k++) tick(4'b0000);
    $display("test_counter_limit done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_random();
    logic [3:0] pat;
    int hold;
    for (int seg = 0; seg < 80; seg++) begin
      pat  = 4'($urandom_range(0, 15));
      hold = int'($urandom_range(1, 14));
      for (int k = 0; k < hold; k++) begin
        tick(pat);
        checks++;
        if ({lvl8, pr8, rl8, ln8, lvl2, pr2, rl2, ln2} !== {ml[0], mp[0], mr[0], mlaunch[0], ml[1], mp[1], mr[1], mlaunch[1]}) begin
          failures++;
          $display("FAIL random_model seg=%0d k=%0d got=%b required=%b", seg, k, {lvl8, pr8, rl8, ln8, lvl2, pr2, rl2, ln2}, {ml[0], mp[0], mr[0], mlaunch[0], ml[1], mp[1], mr[1], mlaunch[1]});
        end
      end
    end
    $display("test_random done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_launch();
    test_reset_mid();
    test_counter_limit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
